out_edge_logger: RTL and testbench

- Downstream observer for the single-output gate-level test netlist.
- Samples the netlist's `out` net every `iccad_clk` cycle and detects level transitions.
- Timestamps each transition with a free-running cycle counter and queues (timestamp, new level) records in a small FIFO.
- Records drain over a valid/ready interface to a bench or trace sink, so the netlist's output activity can be checked against expected switching.

---
 rtl/out_edge_logger.sv | 123 ++++++++++++
 tb/tb_out_edge_logger.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/out_edge_logger.sv
// out_edge_logger: samples a single monitored net, timestamps each level
// transition with a free-running cycle counter and queues (timestamp, level)
// records in a first-word-fall-through FIFO drained over valid/ready.
module out_edge_logger #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             iccad_clk,
  input  logic             iccad_rst,
  input  logic             en,
  input  logic             out_in,
  output logic             level,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [TS_W-1:0]  rec_ts,
  output logic             rec_level,
  output logic [CNT_W-1:0] fill,
  output logic             overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One queued transition: timestamp plus the level the net moved to.
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic            lvl;
  } rec_t;

  rec_t             mem_q [DEPTH];

  logic [TS_W-1:0]  ts_q,       ts_d;
  logic             level_q,    level_d;
  logic [CNT_W-1:0] fill_q,     fill_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic             overflow_q, overflow_d;

  logic             edge_det_c;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;

  // Edge detect and FIFO handshake decisions for this cycle.
  always_comb begin
    edge_det_c = en & (out_in != level_q);
    full_c     = (fill_q == CNT_W'(DEPTH));
    pop_c      = (fill_q != '0) & rec_ready;
    // A pop on a full FIFO frees the slot the incoming record needs.
    push_c     = edge_det_c & (~full_c | pop_c);
    drop_c     = edge_det_c & full_c & ~pop_c;
  end

  // Next-state for counter, sampler, pointers, fill level and sticky flag.
  always_comb begin
    ts_d       = ts_q;
    level_d    = out_in;
    fill_d     = fill_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;

    if (en) begin
      ts_d = ts_q + TS_W'(1);
    end

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase

    if (drop_c) begin
      overflow_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge iccad_clk) begin
    if (iccad_rst) begin
      ts_q       <= '0;
      level_q    <= 1'b0;
      fill_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      level_q    <= level_d;
      fill_q     <= fill_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Record storage; contents need no reset since fill qualifies them.
  always_ff @(posedge iccad_clk) begin
    if (!iccad_rst && push_c) begin
      mem_q[wr_ptr_q] <= '{ts: ts_q, lvl: out_in};
    end
  end

  // Head entry falls through to the outputs.
  always_comb begin
    level     = level_q;
    rec_valid = (fill_q != '0);
    rec_ts    = mem_q[rd_ptr_q].ts;
    rec_level = mem_q[rd_ptr_q].lvl;
    fill      = fill_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_out_edge_logger.sv
// Bench for out_edge_logger: directed vectors, a queue-based reference model
// checked every cycle, and hand-computed literal expectations. Two instances
// share stimulus: TS_W=16 and TS_W=4 (to reach timestamp wrap quickly).
module tb_out_edge_logger;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, out_in, rec_ready;

  logic             a_level, a_valid, a_rlvl, a_ovf;
  logic [15:0]      a_ts;
  logic [CNT_W-1:0] a_fill;
  logic             b_level, b_valid, b_rlvl, b_ovf;
  logic [3:0]       b_ts;
  logic [CNT_W-1:0] b_fill;

  out_edge_logger #(.TS_W(16), .DEPTH(DEPTH)) u_dut16 (
    .iccad_clk(clk), .iccad_rst(rst), .en(en), .out_in(out_in),
    .level(a_level), .rec_valid(a_valid), .rec_ready(rec_ready),
    .rec_ts(a_ts), .rec_level(a_rlvl), .fill(a_fill), .overflow(a_ovf)
  );

  out_edge_logger #(.TS_W(4), .DEPTH(DEPTH)) u_dut4 (
    .iccad_clk(clk), .iccad_rst(rst), .en(en), .out_in(out_in),
    .level(b_level), .rec_valid(b_valid), .rec_ready(rec_ready),
    .rec_ts(b_ts), .rec_level(b_rlvl), .fill(b_fill), .overflow(b_ovf)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: unbounded cycle count, records in a queue.
  typedef struct {
    int unsigned ts;
    logic        lvl;
  } mrec_t;

  mrec_t       mq[$];
  int unsigned m_ts;
  logic        m_lvl;
  logic        m_ovf;
  bit          m_live = 0;

  always @(posedge clk) begin : model
    bit edg;
    if (rst) begin
      mq.delete();
      m_ts   = 0;
      m_lvl  = 1'b0;
      m_ovf  = 1'b0;
      m_live = 1;
    end else if (m_live) begin
      edg = en && (out_in != m_lvl);
      if (mq.size() != 0 && rec_ready) void'(mq.pop_front());
      if (edg) begin
        if (mq.size() < DEPTH) mq.push_back('{ts: m_ts, lvl: out_in});
        else m_ovf = 1'b1;
      end
      m_lvl = out_in;
      if (en) m_ts++;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("a_fill",  32'(a_fill),  32'(mq.size()));
      check("a_valid", 32'(a_valid), 32'(mq.size() != 0));
      check("a_ovf",   32'(a_ovf),   32'(m_ovf));
      check("a_level", 32'(a_level), 32'(m_lvl));
      check("b_fill",  32'(b_fill),  32'(mq.size()));
      check("b_valid", 32'(b_valid), 32'(mq.size() != 0));
      check("b_ovf",   32'(b_ovf),   32'(m_ovf));
      check("b_level", 32'(b_level), 32'(m_lvl));
      if (mq.size() != 0) begin
        check("a_head_ts",  32'(a_ts),   mq[0].ts % 65536);
        check("a_head_lvl", 32'(a_rlvl), 32'(mq[0].lvl));
        check("b_head_ts",  32'(b_ts),   mq[0].ts % 16);
        check("b_head_lvl", 32'(b_rlvl), 32'(mq[0].lvl));
      end
    end
  end

  task automatic cyc(input logic e, input logic o, input logic r);
    rst = 1'b0; en = e; out_in = o; rec_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic o);
    rst = 1'b1; en = 1'b1; out_in = o; rec_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic lit_head(input string name, input int unsigned ts, input logic lvl);
    check({name, "_valid"}, 32'(a_valid), 32'd1);
    check({name, "_ts"},    32'(a_ts),    ts);
    check({name, "_lvl"},   32'(a_rlvl),  32'(lvl));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; out_in = 1'b0; rec_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0);
    check("rst_fill", 32'(a_fill), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);

    // Rise at ts=5, fall at ts=9, sink always ready.
    for (int k = 0; k <= 10; k++) begin
      cyc(1'b1, (k >= 5 && k < 9), 1'b1);
      if (k == 5) lit_head("t1_rise", 5, 1'b1);
      if (k == 9) lit_head("t1_fall", 9, 1'b0);
    end
    check("t1_fill0", 32'(a_fill), 32'd0);
    check("t1_ovf0", 32'(a_ovf), 32'd0);

    // Toggle every cycle with sink stalled: fill to 8, then drops.
    do_reset(1'b0);
    for (int k = 0; k <= 20; k++) begin
      cyc(1'b1, (k % 2 == 0), (k == 20));
      if (k == 7) begin
        check("t2_full", 32'(a_fill), 32'd8);
        check("t2_noovf", 32'(a_ovf), 32'd0);
        lit_head("t2_head0", 0, 1'b1);
      end
      if (k == 8) begin
        check("t2_drop_fill", 32'(a_fill), 32'd8);
        check("t2_drop_ovf", 32'(a_ovf), 32'd1);
      end
    end
    // Full plus pop plus edge at ts=20: accepted, fill stays 8.
    check("t3_fill", 32'(a_fill), 32'd8);
    check("t3_ovf", 32'(a_ovf), 32'd1);
    for (int i = 0; i < 8; i++) begin
      int unsigned t;
      t = (i < 7) ? (i + 1) : 20;
      lit_head("t3_drain", t, (t % 2 == 0));
      cyc(1'b0, 1'b1, 1'b1);
    end
    check("t3_empty", 32'(a_valid), 32'd0);

    // Toggles while disabled are never logged; ts stays frozen at 21.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0);
    check("t4_novalid", 32'(a_valid), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    lit_head("t4_frozen_ts", 24, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);

    // First post-reset cycle with out_in=1 logs (0,1); reset clears all.
    do_reset(1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    lit_head("t5_first", 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t5_fill4", 32'(a_fill), 32'd4);
    do_reset(1'b1);
    check("t5_rst_fill", 32'(a_fill), 32'd0);
    check("t5_rst_valid", 32'(a_valid), 32'd0);
    check("t5_rst_ovf", 32'(a_ovf), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    lit_head("t5_ts_restart", 0, 1'b1);

    // Wrap: toggles at cycles 15 and 17; 4-bit instance sees 15 then 1.
    do_reset(1'b0);
    for (int k = 0; k < 18; k++) cyc(1'b1, (k >= 15 && k < 17), 1'b0);
    check("t6_b_ts0", 32'(b_ts), 32'd15);
    check("t6_b_lvl0", 32'(b_rlvl), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    check("t6_b_ts1", 32'(b_ts), 32'd1);
    check("t6_b_lvl1", 32'(b_rlvl), 32'd0);
    check("t6_a_ts1", 32'(a_ts), 32'd17);
    cyc(1'b0, 1'b0, 1'b1);
    check("t6_empty", 32'(b_fill), 32'd0);

    cyc(1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
